// File: rtl/izh_pkg.sv
// izh_pkg: regular-spiking Izhikevich coefficients and real-to-fixed conversion
package izh_pkg;
    localparam real A_RS = 0.02;
    localparam real B_RS = 0.2;
    localparam real C_RS = -65.0;
    localparam real D_RS = 8.0;
    localparam real VPEAK_RS = 30.0;
    localparam real K2_RS = 0.04;
    localparam real K1_RS = 5.0;
    localparam real K0_RS = 140.0;
    function automatic longint to_fx(input real x, input int fr);
        real s;
        s = x * (2.0 ** fr);
        return (s >= 0.0) ? longint'($rtoi(s + 0.5)) : -longint'($rtoi(0.5 - s));
    endfunction
endpackage

// File: rtl/izh_fx_mul.sv
// izh_fx_mul: signed full-precision fixed-point multiply, arithmetic-shifted right by FR
module izh_fx_mul #(
    parameter int W  = 24,
    parameter int OW = 48,
    parameter int FR = 11
) (
    input  logic signed [W-1:0]  a,
    input  logic signed [W-1:0]  b,
    output logic signed [OW-1:0] p
);
    logic signed [2*W-1:0] full;
    assign full = a * b;
    assign p = OW'(full >>> FR);
endmodule

// File: rtl/izh_neuron.sv
// izh_neuron: fixed-point Izhikevich neuron, one saturating Euler step per clock
module izh_neuron import izh_pkg::*; #(
    parameter int V_WIDTH  = 20,
    parameter int FR_WIDTH = 11,
    parameter int DT_SHIFT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [V_WIDTH-1:0] synin,
    output logic                      synout,
    output logic signed [V_WIDTH-1:0] vout
);
    localparam int IW = V_WIDTH + 4;
    localparam int SW = 2 * IW;
    localparam logic signed [IW-1:0] A_X  = IW'(to_fx(A_RS, FR_WIDTH));
    localparam logic signed [IW-1:0] B_X  = IW'(to_fx(B_RS, FR_WIDTH));
    localparam logic signed [IW-1:0] K1_X = IW'(to_fx(K1_RS, FR_WIDTH));
    localparam logic signed [IW-1:0] K2_X = IW'(to_fx(K2_RS, FR_WIDTH));
    localparam logic signed [SW-1:0] K0_S = SW'(to_fx(K0_RS, FR_WIDTH));
    localparam logic signed [SW-1:0] D_S  = SW'(to_fx(D_RS, FR_WIDTH));
    localparam logic signed [V_WIDTH-1:0] C_V     = V_WIDTH'(to_fx(C_RS, FR_WIDTH));
    localparam logic signed [V_WIDTH-1:0] U0_V    = V_WIDTH'(to_fx(B_RS * C_RS, FR_WIDTH));
    localparam logic signed [V_WIDTH-1:0] VPEAK_V = V_WIDTH'(to_fx(VPEAK_RS, FR_WIDTH));
    localparam logic signed [SW-1:0] VMAX = SW'((longint'(1) <<< (V_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] VMIN = -VMAX - 1;

    function automatic logic signed [V_WIDTH-1:0] sat(input logic signed [SW-1:0] x);
        return V_WIDTH'((x > VMAX) ? VMAX : (x < VMIN) ? VMIN : x);
    endfunction

    logic signed [V_WIDTH-1:0] v, u;
    logic signed [IW-1:0] v_x, u_x, k2v, bv, bu;
    logic signed [SW-1:0] vv, k1v, au, sum_v, v_step, u_step, u_spk;
    logic spike;

    assign v_x = IW'(v);
    assign u_x = IW'(u);
    assign bu = bv - u_x;

    izh_fx_mul #(.W(IW), .OW(IW), .FR(FR_WIDTH)) m_k2v (.a(K2_X), .b(v_x), .p(k2v));
    izh_fx_mul #(.W(IW), .OW(SW), .FR(FR_WIDTH)) m_vv  (.a(k2v),  .b(v_x), .p(vv));
    izh_fx_mul #(.W(IW), .OW(SW), .FR(FR_WIDTH)) m_k1v (.a(K1_X), .b(v_x), .p(k1v));
    izh_fx_mul #(.W(IW), .OW(IW), .FR(FR_WIDTH)) m_bv  (.a(B_X),  .b(v_x), .p(bv));
    izh_fx_mul #(.W(IW), .OW(SW), .FR(FR_WIDTH)) m_au  (.a(A_X),  .b(bu),  .p(au));

    // wide sums keep every intermediate exact; only the stored state saturates
    assign sum_v  = vv + k1v + K0_S - SW'(u) + SW'(synin);
    assign v_step = SW'(v) + (sum_v >>> DT_SHIFT);
    assign u_step = SW'(u) + (au >>> DT_SHIFT);
    assign u_spk  = SW'(u) + D_S;
    assign spike  = (v >= VPEAK_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            v      <= C_V;
            u      <= U0_V;
            synout <= 1'b0;
        end else begin
            v      <= spike ? C_V : sat(v_step);
            u      <= sat(spike ? u_spk : u_step);
            synout <= spike;
        end
    end

    assign vout = v;
endmodule

// File: tb/tb_izh_neuron.sv
// tb_izh_neuron: directed-vector and multi-cycle scenario bench for izh_neuron
module tb_izh_neuron;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [19:0] synin = '0;
    logic synout;
    logic signed [19:0] vout;

    izh_neuron dut (.clk(clk), .reset(reset), .synin(synin), .synout(synout), .vout(vout));

    always #5 clk = ~clk;

    typedef struct { int syn; int v; } vec_t;
    vec_t tbl[8];

    int checks = 0;
    int errors = 0;
    int mism = 0;
    longint mv = -133120;
    longint mu = -26624;
    logic ms = 1'b0;

    function automatic longint clampv(input longint x);
        return (x > 524287) ? 524287 : (x < -524288) ? -524288 : x;
    endfunction

    // reference Euler step in plain integer arithmetic on the hand-converted constants
    task automatic mstep(input longint syn);
        longint k2v, vv, k1v, sv, bv, au;
        if (mv >= 61440) begin
            mv = -133120;
            mu = clampv(mu + 16384);
            ms = 1'b1;
        end else begin
            k2v = (82 * mv) >>> 11;
            vv  = (k2v * mv) >>> 11;
            k1v = (10240 * mv) >>> 11;
            sv  = vv + k1v + 286720 - mu + syn;
            bv  = (410 * mv) >>> 11;
            au  = (41 * (bv - mu)) >>> 11;
            mv  = clampv(mv + (sv >>> 4));
            mu  = clampv(mu + (au >>> 4));
            ms  = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) begin
            mv = -133120;
            mu = -26624;
            ms = 1'b0;
        end else begin
            mstep(longint'(synin));
        end
        if (longint'(vout) != mv || synout != ms) mism++;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int syn);
        reset = 1'b1;
        synin = 20'(syn);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n, ns, bad, dbl, wrap;
        int st[16];
        logic signed [19:0] prevv;
        logic prevs;
        tbl[0] = '{0, -133483};
        tbl[1] = '{16384, -132459};
        tbl[2] = '{-16384, -134507};
        tbl[3] = '{5806, -133120};
        tbl[4] = '{5805, -133121};
        tbl[5] = '{5822, -133119};
        tbl[6] = '{524287, -100715};
        tbl[7] = '{-524288, -166251};

        do_reset(0);
        chk("reset_vout", longint'(vout), -133120);
        chk("reset_synout", longint'(synout), 0);

        for (int i = 0; i < 8; i++) begin
            do_reset(tbl[i].syn);
            tick();
            chk($sformatf("step%0d_vout", i), longint'(vout), tbl[i].v);
            chk($sformatf("step%0d_synout", i), longint'(synout), 0);
        end

        do_reset(0);
        mism = 0;
        ns = 0;
        repeat (3000) begin
            tick();
            if (synout) ns++;
        end
        chk("rest_spikes", ns, 0);
        chk("rest_range", longint'(vout >= -145408 && vout <= -141312), 1);
        chk("rest_model", mism, 0);

        do_reset(0);
        repeat (10) tick();
        synin = 20'sd16384;
        mism = 0;
        ns = 0; bad = 0; dbl = 0; n = 0;
        while (ns < 12 && n < 30000) begin
            prevv = vout;
            prevs = synout;
            tick();
            n++;
            if (synout) begin
                if (ns < 16) st[ns] = n;
                ns++;
                if (vout != -20'sd133120 || prevv < 20'sd61440) bad++;
                if (prevs) dbl++;
            end
        end
        chk("tonic_spikes", longint'(ns >= 12), 1);
        chk("tonic_align", bad, 0);
        chk("tonic_width", dbl, 0);
        chk("tonic_model", mism, 0);
        if (ns >= 12) begin
            for (int k = 10; k < 12; k++) begin
                n = (st[k] - st[k-1]) - (st[k-1] - st[k-2]);
                chk($sformatf("tonic_isi%0d", k), longint'(n >= -1 && n <= 1), 1);
            end
        end

        do_reset(524287);
        mism = 0;
        ns = 0; wrap = 0;
        repeat (2000) begin
            prevv = vout;
            tick();
            if (synout) ns++;
            if (prevv >= 0 && vout < 0 && !synout) wrap++;
        end
        chk("sat_spikes", longint'(ns > 0), 1);
        chk("sat_nowrap", wrap, 0);
        chk("sat_model", mism, 0);

        do_reset(-16384);
        mism = 0;
        ns = 0;
        repeat (3000) begin
            tick();
            if (synout) ns++;
        end
        chk("inhib_spikes", ns, 0);
        chk("inhib_level", longint'(vout < -20'sd143360), 1);
        chk("inhib_model", mism, 0);

        do_reset(16384);
        n = 0;
        while (vout < 20'sd61440 && n < 5000) begin
            tick();
            n++;
        end
        chk("mid_peak_found", longint'(vout >= 20'sd61440), 1);
        reset = 1'b1;
        tick();
        chk("mid_reset_vout", longint'(vout), -133120);
        chk("mid_reset_synout", longint'(synout), 0);
        reset = 1'b0;
        tick();
        chk("mid_first_step", longint'(vout), -132459);
        chk("mid_first_synout", longint'(synout), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
